alu_operand_seq: RTL and testbench
==================================

Name: alu_operand_seq

Overview:
- Issue/writeback stage placed directly upstream of the 6-bit ALU.
- Holds a small register file, accepts one operation at a time over a valid/ready handshake, and drives the ALU's ALUOp, a, b and CarryIn from registers.
- Captures the ALU's Result and CarryOut one cycle later, writes the result back to the register file and keeps a sticky carry flag for add-with-carry chains.

Parameters:
- WIDTH, 6, datapath width; matches the ALU operand width.
- NREGS, 8, number of register-file entries.
- AW, 3, register address width; NREGS = 2**AW.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  request present
- in_ready  output  1  stage can accept; high only in IDLE
- in_load  input  1  1 = write in_imm to in_rd; ALU is not used
- in_op  input  4  ALU opcode; legal values 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR
- in_use_carry  input  1  ADD only: CarryIn = carry flag instead of 0
- in_rd  input  AW  destination register
- in_rs  input  AW  source register for a
- in_rt  input  AW  source register for b
- in_imm  input  WIDTH  immediate for load
- alu_op  output  4  registered, to ALU ALUOp
- alu_a  output  WIDTH  registered, to ALU a
- alu_b  output  WIDTH  registered, to ALU b
- alu_carry_in  output  1  registered, to ALU CarryIn
- alu_result  input  WIDTH  from ALU Result
- alu_carry_out  input  1  from ALU CarryOut
- done  output  1  one-cycle pulse: operation retired
- err  output  1  one-cycle pulse: illegal opcode rejected
- wb_data  output  WIDTH  value written on the last retire
- carry_flag  output  1  sticky carry
- dbg_addr  input  AW  debug read address
- dbg_data  output  WIDTH  combinational read of dbg_addr

Behaviour:
- Reset (reset_n low at a clk edge):
  - State goes to IDLE; all registers are cleared to 0; carry_flag is cleared to 0.
  - alu_op, alu_a, alu_b, alu_carry_in, done, err and wb_data are all 0.
  - Reset takes priority over everything and aborts an EXEC in progress with no writeback.
- Register 0 is hardwired: it always reads 0 and writes to it are discarded. done still pulses for such writes.
- FSM has two states: IDLE and EXEC. in_ready = (state==IDLE).
- Accept occurs when in_valid && in_ready at a clk edge.
  - Load (in_load=1): reg[in_rd] <= in_imm at that edge; wb_data <= in_imm; done=1 in the next cycle; state stays IDLE. Throughput is 1 per cycle.
  - Legal opcode:
    - alu_a <= reg[in_rs]; alu_b <= reg[in_rt]; alu_op <= in_op.
    - alu_carry_in <= 1 for SUB; carry_flag for ADD with in_use_carry; otherwise 0.
    - rd is latched; state goes to EXEC.
  - Illegal opcode: no state change, no write; err=1 in the next cycle.
- EXEC lasts exactly one cycle; the ALU settles combinationally during it.
- At the EXEC-exit edge:
  - reg[rd] <= alu_result; wb_data <= alu_result.
  - carry_flag <= alu_carry_out for ADD/SUB only; it is unchanged for logic ops.
  - done=1 in the following cycle; state goes to IDLE.
- Latency: accept edge T, retire write at edge T+1, done high in the cycle after T+1. ALU ops therefore issue at most every 2 cycles.
- Operands are read at accept. An op that reads a register written by the previous retire sees the new value, because the write has completed before IDLE accepts.
- alu_* outputs hold their last value while IDLE; they are not re-zeroed.
- When a dbg_addr read and a write to the same register share a cycle, dbg_data shows the old value until after the edge.
- Arithmetic is modulo 2**WIDTH; the carry beyond WIDTH is only the ALU's CarryOut.
- done and err are never high in the same cycle.

Optional Feature:
- Macro: ALU_SEQ_OVERFLOW_EN.
- When defined:
  - Adds output ovf_flag (1 bit, reset 0).
  - It updates on ADD/SUB retire as signed overflow, with b_eff = SUB ? ~alu_b : alu_b:
    ovf = (alu_a[W-1]==b_eff[W-1]) && (alu_result[W-1]!=alu_a[W-1])
  - It is held for other ops and loads.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-op, then loads:
  - Stimulus: reset_n low for 2 cycles while in EXEC, then load R1=1, R2=2.
  - Response: in_ready=1; dbg_data R1=000001, R2=000010; carry_flag=0; no done during reset.
- Logic ops on R1=1, R2=2:
  - AND R3 -> wb_data=000000.
  - OR R4 -> 000011.
  - NOR R5 -> 111100.
  - Each op: done 2 cycles after accept; carry_flag unchanged.
- ADD with carry out:
  - Stimulus: load R6=63, R1=1; ADD R7=R6+R1 with in_use_carry=0.
  - Response: wb_data=0, carry_flag=1.
  - Then ADD R3=R1+R2 with in_use_carry=1 -> alu_carry_in=1, wb_data=000100.
- SUB:
  - Stimulus: R2-R1 into R4.
  - Response: alu_carry_in=1, wb_data=000001, carry_flag=1.
  - R1-R2 -> wb_data=111111, carry_flag=0.
- Illegal opcode and R0:
  - Stimulus: in_op=0111 targeting R1.
  - Response: err=1 for one cycle, no done, R1 unchanged.
  - Load R0=5 -> dbg_data at R0 reads 0.
- Overflow flag (ALU_SEQ_OVERFLOW_EN defined):
  - Stimulus: load 31 and 1, ADD.
  - Response: wb_data=100000, ovf_flag=1.
  - Then 3-1 -> ovf_flag=0.

Source files
------------

// File: rtl/alu_operand_seq.sv
// Issue/writeback stage in front of the 6-bit ALU: register file, one-op handshake, sticky carry.
// Optional signed-overflow flag output enabled by defining ALU_SEQ_OVERFLOW_EN.
module alu_operand_seq #(
  parameter int WIDTH = 6,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_load,
  input  logic [3:0]       in_op,
  input  logic             in_use_carry,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  input  logic [WIDTH-1:0] in_imm,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_out,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] wb_data,
  output logic             carry_flag,
`ifdef ALU_SEQ_OVERFLOW_EN
  output logic             ovf_flag,
`endif
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_EXEC = 1'b1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic             r_state;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [AW-1:0]    r_rd;

  logic w_accept;
  logic w_legal;
  logic w_arith;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_legal  = (in_op == OP_AND) || (in_op == OP_OR) || (in_op == OP_ADD) ||
                    (in_op == OP_SUB) || (in_op == OP_NOR);
  // alu_op still holds the issued opcode throughout EXEC
  assign w_arith  = (alu_op == OP_ADD) || (alu_op == OP_SUB);
  assign dbg_data = r_regs[dbg_addr];

`ifdef ALU_SEQ_OVERFLOW_EN
  logic [WIDTH-1:0] w_b_eff;
  logic             w_ovf;
  assign w_b_eff = (alu_op == OP_SUB) ? ~alu_b : alu_b;
  assign w_ovf   = (alu_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                   (alu_result[WIDTH-1] != alu_a[WIDTH-1]);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_rd         <= '0;
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_carry_in <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      wb_data      <= '0;
      carry_flag   <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
      ovf_flag     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          if (in_load) begin
            // register 0 is never written, so it reads 0 forever
            if (in_rd != '0) r_regs[in_rd] <= in_imm;
            wb_data <= in_imm;
            done    <= 1'b1;
          end else if (w_legal) begin
            alu_a        <= r_regs[in_rs];
            alu_b        <= r_regs[in_rt];
            alu_op       <= in_op;
            alu_carry_in <= (in_op == OP_SUB) || ((in_op == OP_ADD) && in_use_carry && carry_flag);
            r_rd         <= in_rd;
            r_state      <= S_EXEC;
          end else begin
            err <= 1'b1;
          end
        end
      end else begin
        if (r_rd != '0) r_regs[r_rd] <= alu_result;
        wb_data <= alu_result;
        if (w_arith) begin
          carry_flag <= alu_carry_out;
`ifdef ALU_SEQ_OVERFLOW_EN
          ovf_flag   <= w_ovf;
`endif
        end
        done    <= 1'b1;
        r_state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_seq.sv
// Scoreboarded bench for alu_operand_seq with a behavioural 6-bit ALU attached.
module tb_alu_operand_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready, in_load, in_use_carry;
  logic [3:0] in_op;
  logic [2:0] in_rd, in_rs, in_rt, dbg_addr;
  logic [5:0] in_imm, alu_a, alu_b, alu_result, wb_data, dbg_data;
  logic [3:0] alu_op;
  logic       alu_carry_in, alu_carry_out, done, err, carry_flag;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic       ovf_flag;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       is_err;
    logic [5:0] wb;
    logic       cf;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  alu_operand_seq dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_op(in_op), .in_use_carry(in_use_carry),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .done(done), .err(err), .wb_data(wb_data), .carry_flag(carry_flag),
`ifdef ALU_SEQ_OVERFLOW_EN
    .ovf_flag(ovf_flag),
`endif
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Reference ALU: SUB computes a + ~b + CarryIn
  logic [6:0] sum;
  always_comb begin
    sum           = 7'd0;
    alu_result    = 6'd0;
    alu_carry_out = 1'b0;
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b1100: alu_result = ~(alu_a | alu_b);
      4'b0010: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b} + {6'd0, alu_carry_in};
        alu_result = sum[5:0]; alu_carry_out = sum[6];
      end
      4'b0110: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {6'd0, alu_carry_in};
        alu_result = sum[5:0]; alu_carry_out = sum[6];
      end
      default: alu_result = 6'd0;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pop one expectation per done/err pulse
  always @(negedge clk) begin
    if (reset_n) begin
      if (done && err) check("done_err_exclusive", 1, 0);
      if (done || err) begin
        if (q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("kind_is_err", int'(err), int'(e.is_err));
          check("wb_data", int'(wb_data), int'(e.wb));
          check("carry_flag", int'(carry_flag), int'(e.cf));
        end
      end
    end
  end

  task automatic issue(input logic ld, input logic [3:0] op, input logic uc,
                       input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [5:0] imm, input logic e_err, input logic [5:0] e_wb,
                       input logic e_cf);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    in_valid = 1'b1; in_load = ld; in_op = op; in_use_carry = uc;
    in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
    e.is_err = e_err; e.wb = e_wb; e.cf = e_cf;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic load(input logic [2:0] rd, input logic [5:0] imm, input logic cf);
    issue(1'b1, 4'b0000, 1'b0, rd, 3'd0, 3'd0, imm, 1'b0, imm, cf);
  endtask

  task automatic alu(input logic [3:0] op, input logic uc, input logic [2:0] rd,
                     input logic [2:0] rs, input logic [2:0] rt,
                     input logic [5:0] e_wb, input logic e_cf);
    issue(1'b0, op, uc, rd, rs, rt, 6'd0, 1'b0, e_wb, e_cf);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic dbg(input logic [2:0] a, input int exp);
    dbg_addr = a;
    #1 check($sformatf("dbg_R%0d", a), int'(dbg_data), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_op = 4'd0; in_use_carry = 1'b0;
    in_rd = 3'd0; in_rs = 3'd0; in_rt = 3'd0; in_imm = 6'd0; dbg_addr = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_alu_op", int'(alu_op), 0);
    check("rst_alu_ab", int'({alu_a, alu_b}), 0);
    check("rst_alu_cin", int'(alu_carry_in), 0);
    check("rst_done_err", int'({done, err}), 0);
    check("rst_wb_data", int'(wb_data), 0);
    check("rst_carry", int'(carry_flag), 0);
    reset_n = 1'b1;

    // Reset during EXEC: op accepted, then reset aborts it with no done
    @(negedge clk);
    in_valid = 1'b1; in_load = 1'b0; in_op = 4'b0001; in_rd = 3'd1; in_rs = 3'd0; in_rt = 3'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("exec_not_ready", int'(in_ready), 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check("post_reset_ready", int'(in_ready), 1);
    check("post_reset_carry", int'(carry_flag), 0);

    load(3'd1, 6'd1, 1'b0);
    load(3'd2, 6'd2, 1'b0);
    drain();
    dbg(3'd1, 1);
    dbg(3'd2, 2);

    alu(4'b0000, 1'b0, 3'd3, 3'd1, 3'd2, 6'b000000, 1'b0);
    alu(4'b0001, 1'b0, 3'd4, 3'd1, 3'd2, 6'b000011, 1'b0);
    alu(4'b1100, 1'b0, 3'd5, 3'd1, 3'd2, 6'b111100, 1'b0);
    drain();
    dbg(3'd5, 60);

    // Done latency: accept edge T, done visible after edge T+1 only
    @(negedge clk);
    in_valid = 1'b1; in_load = 1'b0; in_op = 4'b0001; in_rd = 3'd4; in_rs = 3'd1; in_rt = 3'd2;
    q.push_back('{is_err: 1'b0, wb: 6'd3, cf: 1'b0});
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("lat_no_early_done", int'(done), 0);
    @(posedge clk);
    #1 check("lat_done_t1", int'(done), 1);
    drain();

    load(3'd6, 6'd63, 1'b0);
    load(3'd1, 6'd1, 1'b0);
    alu(4'b0010, 1'b0, 3'd7, 3'd6, 3'd1, 6'd0, 1'b1);
    alu(4'b0010, 1'b1, 3'd3, 3'd1, 3'd2, 6'b000100, 1'b0);
    check("adc_carry_in", int'(alu_carry_in), 1);
    drain();
    dbg(3'd7, 0);

    alu(4'b0110, 1'b0, 3'd4, 3'd2, 3'd1, 6'b000001, 1'b1);
    check("sub_carry_in", int'(alu_carry_in), 1);
    alu(4'b0110, 1'b0, 3'd5, 3'd1, 3'd2, 6'b111111, 1'b0);
    drain();

    issue(1'b0, 4'b0111, 1'b0, 3'd1, 3'd2, 3'd2, 6'd0, 1'b1, 6'b111111, 1'b0);
    drain();
    dbg(3'd1, 1);
    load(3'd0, 6'd5, 1'b0);
    drain();
    dbg(3'd0, 0);

`ifdef ALU_SEQ_OVERFLOW_EN
    load(3'd3, 6'd31, 1'b0);
    load(3'd4, 6'd1, 1'b0);
    alu(4'b0010, 1'b0, 3'd5, 3'd3, 3'd4, 6'b100000, 1'b0);
    drain();
    check("ovf_add", int'(ovf_flag), 1);
    load(3'd3, 6'd3, 1'b0);
    drain();
    check("ovf_hold_load", int'(ovf_flag), 1);
    alu(4'b0110, 1'b0, 3'd5, 3'd3, 3'd4, 6'd2, 1'b1);
    drain();
    check("ovf_sub", int'(ovf_flag), 0);
`endif

    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
